// File: rtl/jk_pattern_tx.sv
// jk_pattern_tx: accepts a WIDTH-bit pattern over valid/ready and sends it
// MSB-first as J/K excitation pairs to an external JK flip-flop. Q is read
// back one cycle after each pair and any mismatch sets a sticky error flag.
//
// Optional feature macro: JK_TX_TOGGLE_EN
//   defined   -> every state change is driven as J=1,K=1 (toggle)
//   undefined -> 0->1 is J=1,K=0 and 1->0 is J=0,K=1
//
// Handshake: a transfer is accepted on a rising edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE while rst is low, and
// tx_valid is ignored at every other time; tx_data is sampled only at accept.
module jk_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prev_q, prev_d;   // bit the flip-flop is expected to hold
  logic [1:0]       jk_q, jk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Excitation pair that moves Q from cur to tgt.
  function automatic logic [1:0] jk_drive(input logic cur, input logic tgt);
    logic [1:0] p;
    p = 2'b00;
    if (cur != tgt) begin
`ifdef JK_TX_TOGGLE_EN
      p = 2'b11;
`else
      p = {tgt, ~tgt};
`endif
    end
    return p;
  endfunction

  // Next-state and next-output logic for the IDLE/SEND/CHECK sequencer.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    jk_d    = 2'b00;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_SEND;
          shift_d = tx_data;
          cnt_d   = '0;
          err_d   = 1'b0;
          // Current Q comes from the feedback pin only for the first bit.
          jk_d    = jk_drive(q_fb, tx_data[WIDTH-1]);
        end
      end
      S_SEND: begin
        // In cycle k>0, Q should already hold bit k-1.
        if ((cnt_q != '0) && (q_fb != prev_q)) err_d = 1'b1;
        prev_d  = shift_q[WIDTH-1];
        shift_d = shift_q << 1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // Later bits are driven from the expected Q, not from q_fb.
          jk_d  = jk_drive(shift_q[WIDTH-1], shift_q[WIDTH-2]);
        end
      end
      S_CHECK: begin
        if (q_fb != prev_q) err_d = 1'b1;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      jk_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      jk_q    <= jk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE) && !rst;
  assign J           = jk_q[1];
  assign K           = jk_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jk_pattern_tx.sv
// Bench for jk_pattern_tx: a behavioural JK flip-flop closes the loop, and
// every transfer is checked cycle by cycle against expectations derived from
// the pattern bits (excitation table, timing, final Q, error flag).
module tb_jk_pattern_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         q_fb;
  logic         J, K, busy, done, err;
  logic [1:0]   dbg_state;

  logic         ff_q;
  logic         stuck_en = 1'b0;
  logic         stuck_val = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   pair_log [0:W-1];
  logic [1:0]   a5_tab [0:W-1];

  jk_pattern_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .q_fb(q_fb), .J(J), .K(K), .busy(busy),
    .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset / flip-flop model
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_fb = stuck_en ? stuck_val : ff_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Excitation needed to take Q from cur to tgt.
  function automatic logic [1:0] exp_pair(input logic cur, input logic tgt);
    if (cur == tgt) return 2'b00;
`ifdef JK_TX_TOGGLE_EN
    return 2'b11;
`else
    return tgt ? 2'b10 : 2'b01;
`endif
  endfunction

  // driver: called at a negedge while idle; returns after the accept edge
  task automatic accept(input logic [W-1:0] d, output logic q0, output int t_acc);
    tx_valid = 1'b1;
    tx_data  = d;
    #1;
    check("ready_at_accept", tx_ready, 1'b1);
    q0 = q_fb;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    t_acc = cyc;
  endtask

  // scoreboard: walks SEND, CHECK and the done cycle of one transfer
  task automatic body(input logic q0, input logic hold_valid, input int t_acc);
    logic [W-1:0] d;
    logic         cur;
    logic         err_exp;
    d = exp_q.pop_front();
    cur = q0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (!hold_valid) tx_valid = 1'b0;
      check("send_jk", {J, K}, exp_pair(cur, d[W-1-k]));
      pair_log[k] = {J, K};
      check("send_busy", busy, 1'b1);
      check("send_done", done, 1'b0);
      check("send_ready", tx_ready, 1'b0);
      if (k == 0) check("err_cleared", err, 1'b0);
      cur = d[W-1-k];
    end
    @(negedge clk);
    check("check_jk", {J, K}, 2'b00);
    check("check_busy", busy, 1'b1);
    @(negedge clk);
    err_exp = stuck_en ? (d != {W{stuck_val}}) : 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_cycle", cyc - t_acc + 1, W + 2);
    check("done_err", err, err_exp);
    check("done_busy", busy, 1'b0);
    check("done_ready", tx_ready, 1'b1);
    check("done_jk", {J, K}, 2'b00);
    if (!stuck_en) check("final_q", ff_q, d[0]);
  endtask

  initial begin
    logic q0;
    int   t1, t2;
    logic b2b;
    int   done_cnt;

    a5_tab = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
`ifdef JK_TX_TOGGLE_EN
    a5_tab = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
`endif

    // reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      check("rst_jk", {J, K}, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_ready", tx_ready, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1'b1);

    // 8'hA5 from Q=0
    check("a5_start_q", q_fb, 1'b0);
    accept(8'hA5, q0, t1);
    body(q0, 1'b0, t1);
    for (int k = 0; k < W; k++) check("a5_seq", pair_log[k], a5_tab[k]);

    // 8'h80 with Q stuck at 0, then an accept that clears err
    stuck_en = 1'b1;
    stuck_val = 1'b0;
    @(negedge clk);
    accept(8'h80, q0, t1);
    body(q0, 1'b0, t1);
    check("stuck_err", err, 1'b1);
    stuck_en = 1'b0;
    accept(8'h3C, q0, t1);
    body(q0, 1'b0, t1);

    // 8'hFF then 8'h00 with tx_valid held high
    @(negedge clk);
    accept(8'hFF, q0, t1);
    body(q0, 1'b1, t1);
    accept(8'h00, q0, t2);
    check("b2b_gap", t2 - t1, W + 2);
    body(q0, 1'b0, t2);

    // reset during SEND cycle 3
    @(negedge clk);
    accept(W'($urandom), q0, t1);
    void'(exp_q.pop_front());
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", tx_ready, 1'b0);
    @(negedge clk);
    check("midrst_jk", {J, K}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_ready_rel", tx_ready, 1'b1);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);

    // randomized transfers with gaps, back-to-back and stuck feedback
    b2b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic nb;
      if (!b2b) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check("idle_jk", {J, K}, 2'b00);
          check("idle_busy", busy, 1'b0);
        end
      end
      stuck_en  = ($urandom_range(0, 3) == 0);
      stuck_val = 1'($urandom_range(0, 1));
      nb = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      accept(W'($urandom), q0, t1);
      body(q0, nb, t1);
      b2b = nb;
    end
    stuck_en = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("end_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_pattern_tx.md
# jk_pattern_tx

Drive side of a JK flip-flop. The block accepts a WIDTH-bit target pattern over a valid/ready handshake and serialises it MSB-first as J/K excitation pairs. An external `jk_ff` driven by these pairs reproduces the pattern on Q, one bit per clock. The block reads Q back, compares it against the expected bit and flags any mismatch. It sits between a pattern source and a `jk_ff` instance, and serves as the stimulus engine for flip-flop characterisation.

## Interface
- `WIDTH`, default 8: pattern length in bits; must be at least 2.

- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_data`  in  WIDTH: target pattern, sent MSB first; sampled only at accept.
- `tx_valid`  in  1: the source offers `tx_data`.
- `tx_ready`  out  1: equals (state == IDLE) && !rst.
- `q_fb`  in  1: Q output of the driven flip-flop.
- `J`, `K`  out  1 each: registered excitation outputs.
- `busy`  out  1: registered; high while in SEND or CHECK.
- `done`  out  1: registered; one-cycle pulse when a transfer completes.
- `err`  out  1: registered; sticky mismatch flag, valid while `done` is high.

## Operation
- **States:** IDLE, SEND, CHECK.
- **Accept:** occurs on a rising edge with `tx_valid && tx_ready`.
  - Latch `tx_data` into the shift register.
  - Clear `err`.
  - Set the bit counter to 0.
  - Go to SEND.
  - Load J/K for bit WIDTH-1, using `q_fb` as sampled at that edge as the current Q.
- **SEND:** lasts exactly WIDTH cycles, indexed k = 0..WIDTH-1.
  - During cycle k, J/K carry the drive for target bit b(k) = `tx_data[WIDTH-1-k]`.
  - The flip-flop loads b(k) at the edge that ends cycle k.
  - For cycles k ≥ 1, compare `q_fb` with b(k-1). Any mismatch sets `err`.
  - The next J/K are computed from the expected Q, b(k), not from `q_fb`.
- **Excitation:**
  - Current Q equals the target: J=0, K=0 (hold).
  - Q changes 0→1: J=1, K=0.
  - Q changes 1→0: J=0, K=1.
- **CHECK:** lasts one cycle.
  - J=K=0.
  - Compare `q_fb` with b(WIDTH-1); a mismatch sets `err`.
  - Next state is IDLE, with `done` = 1 in that first IDLE cycle.
- **IDLE:** J=K=0 and `busy` = 0.
- **Back-to-back:** an accept is allowed in the same cycle that `done` is high.
- **Ignored input:** `tx_valid` is ignored while `busy` is high.
- **`err` hold:** holds its value until the next accept or reset.
- **Reset values:** state IDLE, J=0, K=0, `busy`=0, `done`=0, `err`=0, shift register and counter 0.
- **Reset mid-transfer:** aborts the transfer.
  - On the next cycle, J=K=0 and `busy`=0.
  - No `done` pulse is generated.
  - Any partial pattern is discarded.

## Timing
- Accept at edge E0.
- SEND occupies cycles 1..WIDTH and CHECK occupies cycle WIDTH+1.
- `done` and `tx_ready` are both high in cycle WIDTH+2.
- Throughput is one pattern per WIDTH+2 cycles.
- `q_fb` is sampled one cycle after the corresponding J/K pair is presented.
- `tx_ready` is combinational from the state and `rst`. Every other output is registered.

## Configuration
- `JK_TX_TOGGLE_EN`
  - When defined, every state change (0→1 or 1→0) is driven as J=1, K=1 (toggle). Hold is still J=0, K=0.
  - When undefined, changes use the set/reset encoding given in Operation.
  - Handshake, timing and error checking are identical in both builds.

## Test plan
1. Reset: hold `rst` high for 2 cycles → J=K=0, `busy`=0, `done`=0, `err`=0 and `tx_ready`=0 while `rst` is high; `tx_ready`=1 in the first cycle after release.
2. Send 8'hA5 to a connected `jk_ff` starting at Q=0:
   - J/K sequence 10, 01, 10, 01, 00, 10, 01, 10.
   - `done`=1 in cycle 10 after accept, with `err`=0.
   - Final Q=1.
3. Repeat case 2 with `JK_TX_TOGGLE_EN` defined:
   - J/K sequence 11, 11, 11, 11, 00, 11, 11, 11.
   - Same Q trace, `err`=0.
4. Send 8'hFF then 8'h00 with `tx_valid` held high, starting at Q=0:
   - J/K sequence 10 then seven 00 pairs, then 01 then seven 00 pairs.
   - The second accept happens in the first word's `done` cycle; the accepts are 10 cycles apart.
5. Send 8'h80 with `q_fb` stuck at 0 → `err`=1 when `done` pulses; the next accept clears `err` to 0.
6. Assert `rst` for one cycle during SEND cycle 3 → the next cycle has J=K=0 and `busy`=0; no `done` pulse appears within 12 cycles; `tx_ready`=1 after release.
